// File: rtl/rssb_serial_mem.sv
// rssb_serial_mem: bit-serial operand memory for the 1-bit RSSB CPU.
// Reads one word, streams it LSB-first as operand bits, captures the serial
// result in the same slots and optionally writes the reassembled word back.
// A parallel host port preloads/inspects memory while idle.
// Optional feature macro: RSSB_SERIAL_MEM_PARITY_EN (adds an even-parity slot
// after the data bits and the par_err_o output).
module rssb_serial_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [AW-1:0]    addr_i,
  input  logic             wb_i,
  output logic             bit_o,
  output logic             bit_vld_o,
  input  logic             result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] last_o,
  input  logic             host_we_i,
  input  logic [AW-1:0]    host_addr_i,
  input  logic [WIDTH-1:0] host_wdata_i,
  output logic [WIDTH-1:0] host_rdata_o,
  output logic             host_err_o
`ifdef RSSB_SERIAL_MEM_PARITY_EN
  ,
  output logic             par_err_o
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] op_sreg;
  logic [WIDTH-1:0] res_sreg;
  logic [AW-1:0]    addr_q;
  logic             wb_q;
  logic [CW-1:0]    cnt;
  logic             wb_ok_c;
`ifdef RSSB_SERIAL_MEM_PARITY_EN
  logic             par_q;
  logic             par_bad_q;
`endif

  // Operand bit is the LSB of the shift register; it drains to zero outside SHIFT.
  assign bit_o = op_sreg[0];

  // Host read port is live in every state.
  assign host_rdata_o = mem[host_addr_i];

  // Write-back is allowed when requested and (if enabled) the parity echo matched.
`ifdef RSSB_SERIAL_MEM_PARITY_EN
  assign wb_ok_c = wb_q & ~par_bad_q;
`else
  assign wb_ok_c = wb_q;
`endif

  // Transaction FSM, serial datapath and memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_sreg    <= '0;
      res_sreg   <= '0;
      addr_q     <= '0;
      wb_q       <= 1'b0;
      cnt        <= '0;
      bit_vld_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      last_o     <= '0;
      host_err_o <= 1'b0;
`ifdef RSSB_SERIAL_MEM_PARITY_EN
      par_q      <= 1'b0;
      par_bad_q  <= 1'b0;
      par_err_o  <= 1'b0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      done_o     <= 1'b0;
`ifdef RSSB_SERIAL_MEM_PARITY_EN
      par_err_o  <= 1'b0;
`endif
      // Host writes are only honoured in IDLE without a competing start.
      host_err_o <= host_we_i & ((state != IDLE) | start_i);

      case (state)
        IDLE: begin
          if (start_i) begin
            addr_q <= addr_i;
            wb_q   <= wb_i;
            busy_o <= 1'b1;
            state  <= LOAD;
          end else if (host_we_i) begin
            mem[host_addr_i] <= host_wdata_i;
          end
        end

        LOAD: begin
          op_sreg   <= mem[addr_q];
          cnt       <= '0;
          bit_vld_o <= 1'b1;
`ifdef RSSB_SERIAL_MEM_PARITY_EN
          par_q     <= ^mem[addr_q];
`endif
          state     <= SHIFT;
        end

        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt < CW'(WIDTH)) begin
            res_sreg <= {result_i, res_sreg[WIDTH-1:1]};
            op_sreg  <= op_sreg >> 1;
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef RSSB_SERIAL_MEM_PARITY_EN
              op_sreg   <= WIDTH'(par_q);
`else
              bit_vld_o <= 1'b0;
              state     <= WB;
`endif
            end
          end else begin
`ifdef RSSB_SERIAL_MEM_PARITY_EN
            par_bad_q <= result_i ^ (^res_sreg);
`endif
            op_sreg   <= '0;
            bit_vld_o <= 1'b0;
            state     <= WB;
          end
        end

        WB: begin
          if (wb_ok_c) begin
            mem[addr_q] <= res_sreg;
          end
          last_o    <= res_sreg;
          busy_o    <= 1'b0;
          done_o    <= 1'b1;
`ifdef RSSB_SERIAL_MEM_PARITY_EN
          par_err_o <= par_bad_q;
`endif
          state     <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rssb_serial_mem.md
Name: rssb_serial_mem

Overview:
- Bit-serial operand memory on the far side of the 1-bit RSSB CPU's data/result stream.
- On each transaction it reads one word and drives it LSB-first as the CPU's operand bit.
- In the same cycles it captures the CPU's serial result bit, then writes the reassembled word back (the read-modify-write half of RSSB).
- A parallel host port preloads and inspects memory while the block is idle.

Parameters:
- WIDTH, 8, bits per memory word and serial transfer length (>=2).
- DEPTH, 16, number of words (power of two).
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to begin a serial transaction.
- addr_i  in  AW  word address, sampled with start_i.
- wb_i  in  1  sampled with start_i; 1 = write captured result back.
- bit_o  out  1  serial operand bit to CPU (LSB first).
- bit_vld_o  out  1  high during every bit slot.
- result_i  in  1  serial result bit from CPU, sampled in each bit slot.
- busy_o  out  1  high from the cycle after accepted start until return to IDLE.
- done_o  out  1  one-cycle pulse at end of transaction.
- last_o  out  WIDTH  last captured result word, held until next done.
- host_we_i  in  1  host write strobe.
- host_addr_i  in  AW  host address.
- host_wdata_i  in  WIDTH  host write data.
- host_rdata_o  out  WIDTH  combinational mem[host_addr_i].
- host_err_o  out  1  one-cycle pulse when host_we_i is dropped because busy.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - bit_o, bit_vld_o, busy_o, done_o, host_err_o = 0.
  - last_o = 0; all memory words = 0.
  - Bit counter and shift registers = 0.
- FSM states: IDLE, LOAD, SHIFT, WB, DONE.
- IDLE:
  - start_i=1 → latch addr_i and wb_i, go to LOAD.
  - host_we_i=1 and start_i=0 → mem[host_addr_i] <= host_wdata_i.
  - If start_i and host_we_i are both 1, start wins, the host write is dropped, and host_err_o pulses.
- LOAD (1 cycle): op_sreg <= mem[addr]; cnt <= 0; busy_o=1.
- SHIFT (exactly WIDTH cycles):
  - bit_o = op_sreg[0]; bit_vld_o = 1.
  - On each edge, op_sreg shifts right and the result shift register takes result_i in at its MSB (after WIDTH cycles the first bit is in bit 0).
  - cnt increments; leave SHIFT when cnt == WIDTH-1.
- WB (1 cycle): if the latched wb = 1, mem[addr] <= captured word; last_o <= captured word regardless of wb.
- DONE (1 cycle): done_o = 1, busy_o = 0; next state IDLE.
- Latency: start accepted at edge E0. Bit k is valid in cycle E0+2+k. done_o is high in cycle E0+WIDTH+3. A new start is accepted in the cycle after done.
- While not IDLE:
  - start_i is ignored (no queuing).
  - host_we_i is dropped with a host_err_o pulse.
  - host_rdata_o stays live, and shows the old word until WB commits.
- Simultaneous events:
  - A WB to an address equals a host read of the same address → host_rdata_o shows the new value from the cycle after WB.
  - result_i is sampled only in SHIFT; it is ignored elsewhere.
- Reset mid-transaction aborts with no write-back; memory is cleared.
- Counter: width $clog2(WIDTH)+1; never wraps within a transaction.

Optional Feature:
- Macro RSSB_SERIAL_MEM_PARITY_EN.
- Defined:
  - SHIFT gets one extra slot after the last data bit, in which bit_o = even parity (XOR of the original word) with bit_vld_o=1.
  - result_i in that slot is compared with the XOR of the captured word; a mismatch suppresses write-back and pulses extra output par_err_o with done_o.
  - Latency grows by 1: done in cycle E0+WIDTH+4.
- Undefined: no par_err_o port; timing exactly as above.

Test Plan:
- Reset then idle: host_rdata_o=0 at all addresses; all outputs 0; assert rst mid-idle → still 0.
- Preload and read: host write mem[3]=8'hA5, start addr=3 wb=0 → bit_o sequence 1,0,1,0,0,1,0,1 on E0+2..E0+9; done at E0+11; mem[3] still A5.
- Write-back: preload mem[5]=8'h0F, start addr=5 wb=1, drive result_i 0,1,1,1,0,0,0,0 → last_o=8'h0E, mem[5]=8'h0E after done.
- Busy collisions: host_we to addr 5 and second start during SHIFT → host_err_o pulses, mem unchanged, only one done.
- Reset mid-SHIFT at bit 4 with wb=1 → outputs 0 immediately, mem[addr]=0, next start behaves normally.
- Parity (macro on): mem[1]=8'h07, start wb=1; echo parity slot wrong → par_err_o=1 with done_o, mem[1] unchanged. Echo it correctly → write-back occurs.
